// File: rtl/rvm_divider.sv
// 32-bit RISC-V M-extension divider (DIV/DIVU/REM/REMU).
// Restoring shift-subtract, one quotient bit per cycle; divide-by-zero and signed overflow bypass CALC.
module rvm_divider (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic [1:0]  op,
  input  logic [31:0] lhs,
  input  logic [31:0] rhs,
  input  logic        flush,
  output logic        busy,
  output logic        valid,
  output logic [31:0] result
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state, state_n;
  logic        rem_sel, neg_q, neg_r;
  logic [31:0] quo, dvs;
  logic [32:0] rem;
  logic [4:0]  cnt;
  logic        accept;

  // request-side decode
  logic        sgn_in, div0, ovf, special;
  logic [31:0] spec_res, lhs_mag, rhs_mag;

  assign sgn_in   = ~op[0];
  assign div0     = (rhs == 32'd0);
  assign ovf      = sgn_in && (lhs == 32'h8000_0000) && (rhs == 32'hFFFF_FFFF);
  assign special  = div0 | ovf;
  assign spec_res = div0 ? (op[1] ? lhs : 32'hFFFF_FFFF)
                         : (op[1] ? 32'd0 : 32'h8000_0000);
  assign lhs_mag  = (sgn_in & lhs[31]) ? -lhs : lhs;
  assign rhs_mag  = (sgn_in & rhs[31]) ? -rhs : rhs;

  // one restoring step: the borrow of the 33-bit trial subtraction is its sign bit
  logic [32:0] shifted, diff, rem_n;
  logic [31:0] quo_n, q_f, r_f, calc_res;
  logic        qbit;

  assign shifted  = {rem[31:0], quo[31]};
  assign diff     = shifted - {1'b0, dvs};
  assign qbit     = ~diff[32];
  assign rem_n    = qbit ? diff : shifted;
  assign quo_n    = {quo[30:0], qbit};
  assign q_f      = neg_q ? -quo_n : quo_n;
  assign r_f      = neg_r ? -rem_n[31:0] : rem_n[31:0];
  assign calc_res = rem_sel ? r_f : q_f;

  assign busy  = (state != IDLE);
  assign valid = (state == DONE);

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    case (state)
      IDLE: if (req && !flush) begin
        accept  = 1'b1;
        state_n = special ? DONE : CALC;
      end
      CALC: if (flush)             state_n = IDLE;
            else if (cnt == 5'd31) state_n = DONE;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      rem_sel <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      quo     <= '0;
      dvs     <= '0;
      rem     <= '0;
      cnt     <= '0;
      result  <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        rem_sel <= op[1];
        neg_q   <= sgn_in & (lhs[31] ^ rhs[31]);
        neg_r   <= sgn_in & lhs[31];
        quo     <= lhs_mag;
        dvs     <= rhs_mag;
        rem     <= '0;
        cnt     <= '0;
        if (special) result <= spec_res;
      end else if (state == CALC && !flush) begin
        rem <= rem_n;
        quo <= quo_n;
        cnt <= cnt + 5'd1;
        if (cnt == 5'd31) result <= calc_res;
      end
    end
  end

endmodule

// File: tb/tb_rvm_divider.sv
// Self-checking bench for rvm_divider: directed corners, flush/reset aborts, random ops vs arithmetic model.
module tb_rvm_divider;

  logic        clk = 1'b0;
  logic        resetn, req, flush;
  logic [1:0]  op;
  logic [31:0] lhs, rhs;
  logic        busy, valid;
  logic [31:0] result;

  int tests = 0;
  int fails = 0;
  logic [31:0] last_res = 32'd0;

  rvm_divider dut (
    .clk(clk), .resetn(resetn), .req(req), .op(op), .lhs(lhs), .rhs(rhs),
    .flush(flush), .busy(busy), .valid(valid), .result(result)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = a; sb = b;
    if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'd0 : a;
    case (o)
      2'b00:   return sa / sb;
      2'b01:   return a / b;
      2'b10:   return sa % sb;
      default: return a % b;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  // Called at a negedge; returns at the negedge of the idle cycle right after DONE.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input bit inj);
    int lat;
    logic [31:0] e;
    bit sp;
    e  = ref_model(o, a, b);
    sp = (b == 32'd0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    req = 1'b1; op = o; lhs = a; rhs = b;
    @(negedge clk);
    req = 1'b0; op = 2'($urandom); lhs = $urandom; rhs = $urandom;
    lat = 1;
    while (!valid && lat < 60) begin
      req = inj && (lat == 5);
      @(negedge clk);
      lat++;
    end
    req = 1'b0;
    chk("latency", lat, sp ? 32'd1 : 32'd33);
    chk("busy_in_done", 32'(busy), 32'd1);
    chk("result", result, e);
    last_res = e;
    @(negedge clk);
    chk("valid_single", 32'(valid), 32'd0);
    chk("idle_after_done", 32'(busy), 32'd0);
  endtask

  initial begin
    int nv;
    resetn = 1'b0; req = 1'b0; flush = 1'b0; op = 2'b00; lhs = '0; rhs = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_valid", 32'(valid), 32'd0);
    chk("reset_result", result, 32'd0);
    resetn = 1'b1;

    // first req accepted right after reset release
    run_op(2'b01, 32'd100, 32'd7, 1'b0);
    run_op(2'b11, 32'd100, 32'd7, 1'b0);
    run_op(2'b00, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op(2'b10, 32'd7, 32'hFFFF_FFFE, 1'b0);
    run_op(2'b01, 32'd5, 32'd0, 1'b0);
    run_op(2'b11, 32'd5, 32'd0, 1'b0);
    run_op(2'b00, 32'd5, 32'd0, 1'b0);
    run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    // second req during CALC must be ignored
    run_op(2'b01, 32'd1000, 32'd3, 1'b1);
    run_op(2'b11, 32'd1000, 32'd3, 1'b0);

    // flush at CALC cycle 10
    req = 1'b1; op = 2'b01; lhs = 32'd12345; rhs = 32'd11;
    @(negedge clk);
    req = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_valid", 32'(valid), 32'd0);
    nv = 0;
    repeat (40) begin @(negedge clk); if (valid) nv++; end
    chk("flush_no_valid", nv, 32'd0);
    chk("flush_result_held", result, last_res);

    // flush together with req in IDLE drops the request
    req = 1'b1; flush = 1'b1; op = 2'b00; lhs = 32'd9; rhs = 32'd3;
    @(negedge clk);
    req = 1'b0; flush = 1'b0;
    chk("flush_req_drop", 32'(busy), 32'd0);

    // reset pulse at CALC cycle 20
    req = 1'b1; op = 2'b00; lhs = 32'd777; rhs = 32'd5;
    @(negedge clk);
    req = 1'b0;
    repeat (19) @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_valid", 32'(valid), 32'd0);
    chk("rst_mid_result", result, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    nv = 0;
    repeat (40) begin @(negedge clk); if (valid) nv++; end
    chk("rst_no_valid", nv, 32'd0);

    for (int i = 0; i < 1500; i++) begin
      run_op(2'($urandom), pick(), pick(), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
